// File: rtl/dff_drv_arb.sv
// dff_drv_arb
// Shares one dff DUT among NREQ bench drivers. Each driver asks for a
// single-bit transaction. This block does the following for one transaction:
// grants one requester round-robin, drives din, waits out the DUT latency,
// samples dout, and returns the captured bit with an expected-value compare.
//
// Parameters:
//   NREQ  number of requesters (2..8)
//   LAT   DUT clock-edge latency from din sample to dout valid (1..4)
// Ports:
//   clk, rst            clock (rising edge), async active-high reset
//   en                  arbitration enable; low blocks new grants
//   req/req_din/req_exp per-requester request level, bit to drive, expected dout
//   gnt                 one-hot grant, single-cycle pulse
//   din / dout          to / from the shared DUT
//   rsp_vld             single-cycle response strobe
//   rsp_id              requester index of the response
//   rsp_dout            captured dout
//   rsp_match           rsp_dout equals the expected value
//   busy                high in any state other than IDLE
//   txn_cnt/err_cnt     saturating completed / mismatched transaction counts
module dff_drv_arb #(
  parameter int NREQ = 4,
  parameter int LAT  = 1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    en,
  input  logic [NREQ-1:0]         req,
  input  logic [NREQ-1:0]         req_din,
  input  logic [NREQ-1:0]         req_exp,
  output logic [NREQ-1:0]         gnt,
  output logic                    din,
  input  logic                    dout,
  output logic                    rsp_vld,
  output logic [$clog2(NREQ)-1:0] rsp_id,
  output logic                    rsp_dout,
  output logic                    rsp_match,
  output logic                    busy,
  output logic [15:0]             txn_cnt,
  output logic [15:0]             err_cnt
);

  localparam int IDW = $clog2(NREQ);

  typedef enum logic [1:0] {IDLE, WAIT, CAPTURE} state_t;

  state_t         state, state_nxt;
  logic [IDW-1:0] ptr, id, winner, cand;
  logic           exp_q;
  logic [2:0]     cnt;
  logic           found, grant, capture;

  // Round-robin pick: scan from ptr+1 upward with wrap, first asserted
  // request wins. The scan ends at ptr itself, so the last winner is
  // considered only after everyone else.
  always_comb begin
    winner = ptr;
    found  = 1'b0;
    cand   = '0;
    for (int i = 1; i <= NREQ; i++) begin
      cand = IDW'((int'(ptr) + i) % NREQ);
      if (!found && req[cand]) begin
        winner = cand;
        found  = 1'b1;
      end
    end
  end

  // Next-state logic. A grant is only possible from IDLE. Requests seen
  // in other states simply wait.
  always_comb begin
    state_nxt = state;
    grant     = 1'b0;
    capture   = 1'b0;
    case (state)
      IDLE: begin
        if (en && found) begin
          grant     = 1'b1;
          state_nxt = WAIT;
        end
      end
      WAIT: begin
        if (cnt <= 3'd1) state_nxt = CAPTURE;
      end
      CAPTURE: begin
        capture   = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Datapath registers.
  // gnt and rsp_vld default low every edge, so each one is a one-cycle pulse.
  // din only changes on a grant, so it holds between transactions.
  // ptr resets to NREQ-1, so requester 0 wins the first grant.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      gnt       <= '0;
      din       <= 1'b0;
      exp_q     <= 1'b0;
      id        <= '0;
      ptr       <= IDW'(NREQ - 1);
      cnt       <= '0;
      rsp_vld   <= 1'b0;
      rsp_id    <= '0;
      rsp_dout  <= 1'b0;
      rsp_match <= 1'b0;
      txn_cnt   <= '0;
      err_cnt   <= '0;
    end else begin
      gnt     <= '0;
      rsp_vld <= 1'b0;
      if (grant) begin
        gnt[winner] <= 1'b1;
        din         <= req_din[winner];
        exp_q       <= req_exp[winner];
        id          <= winner;
        ptr         <= winner;
        cnt         <= 3'(LAT);
      end
      if (state == WAIT) cnt <= cnt - 3'd1;
      if (capture) begin
        rsp_vld   <= 1'b1;
        rsp_dout  <= dout;
        rsp_id    <= id;
        rsp_match <= (dout == exp_q);
        if (txn_cnt != 16'hFFFF) txn_cnt <= txn_cnt + 16'd1;
        if ((dout != exp_q) && (err_cnt != 16'hFFFF)) err_cnt <= err_cnt + 16'd1;
      end
    end
  end

  assign busy = (state != IDLE);

endmodule

// File: tb/tb_dff_drv_arb.sv
// tb_dff_drv_arb
// Directed self-checking bench for dff_drv_arb.
// Two instances are used:
//   - one built with LAT=1, which carries most scenarios;
//   - one built with LAT=3, which checks the latency and busy window.
// Each instance has a small behavioural dff with the matching latency.
module tb_dff_drv_arb;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       en  = 1'b0;
  logic [3:0] req = '0, req_din = '0, req_exp = '0;
  logic [3:0] gnt;
  logic       din;
  logic       dout = 1'b0;
  logic       rsp_vld, rsp_dout, rsp_match, busy;
  logic [1:0] rsp_id;
  logic [15:0] txn_cnt, err_cnt;

  logic [3:0] req3 = '0, req_din3 = '0, req_exp3 = '0;
  logic [3:0] gnt3;
  logic       din3;
  logic       rsp_vld3, rsp_dout3, rsp_match3, busy3;
  logic [1:0] rsp_id3;
  logic [15:0] txn_cnt3, err_cnt3;
  logic [2:0] pipe3 = '0;

  int checks = 0;
  int errors = 0;

  dff_drv_arb #(.NREQ(4), .LAT(1)) dut (
    .clk(clk), .rst(rst), .en(en), .req(req), .req_din(req_din), .req_exp(req_exp),
    .gnt(gnt), .din(din), .dout(dout), .rsp_vld(rsp_vld), .rsp_id(rsp_id),
    .rsp_dout(rsp_dout), .rsp_match(rsp_match), .busy(busy),
    .txn_cnt(txn_cnt), .err_cnt(err_cnt)
  );

  dff_drv_arb #(.NREQ(4), .LAT(3)) dut3 (
    .clk(clk), .rst(rst), .en(1'b1), .req(req3), .req_din(req_din3), .req_exp(req_exp3),
    .gnt(gnt3), .din(din3), .dout(pipe3[2]), .rsp_vld(rsp_vld3), .rsp_id(rsp_id3),
    .rsp_dout(rsp_dout3), .rsp_match(rsp_match3), .busy(busy3),
    .txn_cnt(txn_cnt3), .err_cnt(err_cnt3)
  );

  always #5 clk = ~clk;

  // Behavioural DUTs: one edge of latency, and three edges of latency
  always @(posedge clk) begin
    dout  <= din;
    pipe3 <= {pipe3[1:0], din3};
  end

  // Safety net so the run always ends
  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checks++;
    if (observed !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
    end
  endtask

  task automatic stepCycle();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic [3:0] r, input logic [3:0] d,
                               input logic [3:0] e);
    req     = r;
    req_din = d;
    req_exp = e;
  endtask

  task automatic doReset();
    applyStimulus(4'b0000, 4'b0000, 4'b0000);
    req3 = '0;
    rst  = 1'b1;
    stepCycle();
    rst  = 1'b0;
  endtask

  // Step until a grant appears on the LAT=1 instance. A wait that runs out
  // of budget is reported as a failed comparison.
  task automatic waitGrant(input string tag, output int steps);
    steps = 0;
    do begin
      stepCycle();
      steps++;
    end while (gnt == 4'b0000 && steps < 20);
    checkOutput({tag, "_seen"}, 32'(gnt != 4'b0000), 32'd1);
  endtask

  initial begin
    int s;
    int order[6] = '{0, 1, 2, 3, 0, 3};
    int spacing[6] = '{1, 3, 3, 3, 3, 3};
    int cntA, cntB, vldStep;
    logic capDout, capMatch;
    logic [1:0] capId;

    // Reset values
    #1;
    checkOutput("rst_gnt", 32'(gnt), 32'd0);
    checkOutput("rst_din", 32'(din), 32'd0);
    checkOutput("rst_vld", 32'(rsp_vld), 32'd0);
    checkOutput("rst_busy", 32'(busy), 32'd0);
    checkOutput("rst_rsp", 32'({rsp_id, rsp_dout, rsp_match}), 32'd0);
    checkOutput("rst_cnt", 32'({txn_cnt, err_cnt}), 32'd0);
    stepCycle();
    rst = 1'b0;

    // Single requester 2, matching data
    en = 1'b1;
    applyStimulus(4'b0100, 4'b0100, 4'b0100);
    waitGrant("t1", s);
    checkOutput("t1_lat", 32'(s), 32'd1);
    checkOutput("t1_gnt", 32'(gnt), 32'h4);
    checkOutput("t1_din", 32'(din), 32'd1);
    checkOutput("t1_busy0", 32'(busy), 32'd1);
    applyStimulus(4'b0000, 4'b0000, 4'b0000);
    stepCycle();
    checkOutput("t1_gnt_pulse", 32'(gnt), 32'd0);
    checkOutput("t1_vld_early", 32'(rsp_vld), 32'd0);
    checkOutput("t1_busy1", 32'(busy), 32'd1);
    stepCycle();
    checkOutput("t1_vld", 32'(rsp_vld), 32'd1);
    checkOutput("t1_id", 32'(rsp_id), 32'd2);
    checkOutput("t1_dout", 32'(rsp_dout), 32'd1);
    checkOutput("t1_match", 32'(rsp_match), 32'd1);
    checkOutput("t1_txn", 32'(txn_cnt), 32'd1);
    checkOutput("t1_busy2", 32'(busy), 32'd0);
    stepCycle();
    checkOutput("t1_vld_pulse", 32'(rsp_vld), 32'd0);

    // All four requesting from reset, then 0 and 3 re-requesting
    doReset();
    applyStimulus(4'b1111, 4'b0110, 4'b0110);
    for (int k = 0; k < 6; k++) begin
      waitGrant($sformatf("rr%0d", k), s);
      checkOutput($sformatf("rr%0d_gnt", k), 32'(gnt), 32'(1 << order[k]));
      checkOutput($sformatf("rr%0d_gap", k), 32'(s), 32'(spacing[k]));
      req = req & ~gnt;
      if (k == 3) req = req | 4'b1001;
    end
    req = 4'b0000;
    stepCycle();
    stepCycle();
    checkOutput("rr_txn", 32'(txn_cnt), 32'd6);
    checkOutput("rr_err", 32'(err_cnt), 32'd0);

    // Mismatch: drive 0, expect 1
    doReset();
    checkOutput("mm_txn0", 32'(txn_cnt), 32'd0);
    checkOutput("mm_err0", 32'(err_cnt), 32'd0);
    applyStimulus(4'b0010, 4'b0000, 4'b0010);
    waitGrant("mm", s);
    checkOutput("mm_gnt", 32'(gnt), 32'h2);
    applyStimulus(4'b0000, 4'b0000, 4'b0000);
    stepCycle();
    stepCycle();
    checkOutput("mm_vld", 32'(rsp_vld), 32'd1);
    checkOutput("mm_id", 32'(rsp_id), 32'd1);
    checkOutput("mm_dout", 32'(rsp_dout), 32'd0);
    checkOutput("mm_match", 32'(rsp_match), 32'd0);
    checkOutput("mm_err", 32'(err_cnt), 32'd1);
    checkOutput("mm_txn", 32'(txn_cnt), 32'd1);

    // Reset pulsed while WAIT holds a transaction driving din=1
    applyStimulus(4'b0100, 4'b0100, 4'b0100);
    waitGrant("wr", s);
    checkOutput("wr_din1", 32'(din), 32'd1);
    applyStimulus(4'b0000, 4'b0000, 4'b0000);
    rst = 1'b1;
    #1;
    checkOutput("wr_async", 32'({gnt, busy, din}), 32'd0);
    checkOutput("wr_cnt", 32'({txn_cnt, err_cnt}), 32'd0);
    #3;
    rst = 1'b0;
    cntA = 0;
    cntB = 0;
    for (int i = 0; i < 4; i++) begin
      stepCycle();
      cntA += int'(rsp_vld);
      cntB += int'(gnt != 4'b0000);
    end
    checkOutput("wr_no_vld", 32'(cntA), 32'd0);
    checkOutput("wr_no_gnt", 32'(cntB), 32'd0);
    checkOutput("wr_din0", 32'(din), 32'd0);
    checkOutput("wr_txn", 32'(txn_cnt), 32'd0);
    applyStimulus(4'b1111, 4'b0000, 4'b0000);
    waitGrant("wr_next", s);
    checkOutput("wr_next_gnt", 32'(gnt), 32'h1);
    applyStimulus(4'b0000, 4'b0000, 4'b0000);
    stepCycle();
    stepCycle();

    // en low blocks grants; dropping en during WAIT still completes
    en = 1'b0;
    applyStimulus(4'b1111, 4'b1111, 4'b1111);
    cntA = 0;
    cntB = 0;
    for (int i = 0; i < 10; i++) begin
      stepCycle();
      cntA += int'(gnt != 4'b0000);
      cntB += int'(busy);
    end
    checkOutput("en_no_gnt", 32'(cntA), 32'd0);
    checkOutput("en_no_busy", 32'(cntB), 32'd0);
    en = 1'b1;
    waitGrant("en", s);
    checkOutput("en_gnt", 32'(gnt), 32'h2);
    en = 1'b0;
    applyStimulus(4'b0000, 4'b0000, 4'b0000);
    stepCycle();
    checkOutput("en_busy", 32'(busy), 32'd1);
    stepCycle();
    checkOutput("en_vld", 32'(rsp_vld), 32'd1);
    checkOutput("en_id", 32'(rsp_id), 32'd1);
    checkOutput("en_txn", 32'(txn_cnt), 32'd2);

    // LAT=3 instance: response 4 edges after the grant edge, busy 4 cycles
    req3     = 4'b0001;
    req_din3 = 4'b0001;
    req_exp3 = 4'b0001;
    stepCycle();
    checkOutput("l3_gnt", 32'(gnt3), 32'h1);
    req3 = 4'b0000;
    cntA = int'(busy3);
    vldStep = 0;
    capDout = 1'b0;
    capMatch = 1'b0;
    capId = 2'd3;
    for (int i = 1; i <= 6; i++) begin
      stepCycle();
      cntA += int'(busy3);
      if (rsp_vld3) begin
        vldStep  = i;
        capDout  = rsp_dout3;
        capMatch = rsp_match3;
        capId    = rsp_id3;
      end
    end
    checkOutput("l3_busy_cycles", 32'(cntA), 32'd4);
    checkOutput("l3_vld_edge", 32'(vldStep), 32'd4);
    checkOutput("l3_dout", 32'(capDout), 32'd1);
    checkOutput("l3_match", 32'(capMatch), 32'd1);
    checkOutput("l3_id", 32'(capId), 32'd0);
    checkOutput("l3_txn", 32'(txn_cnt3), 32'd1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
